mod100_bcd_display: RTL

Downstream consumer of the mod-100 time-of-day counter. Takes the counter's 7-bit binary value and converts it to two BCD digits with a sequential shift-add-3 (double-dabble) engine. It drives a time-multiplexed 2-digit seven-segment display and flags the 99->0 wrap as a one-cycle pulse. It sits between the counter and the board display pins, in the same clock domain as the counter.

---
 rtl/mod100_disp_pkg.sv | 37 +++
 rtl/bin2bcd_seq.sv | 89 ++++++++
 rtl/mod100_bcd_display.sv | 77 +++++++
 3 files changed

// File: rtl/mod100_disp_pkg.sv
// Shared types and constants for the mod-100 BCD display path:
// converter FSM states, field widths and the seven-segment glyph table.
package mod100_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    localparam int BIN_W        = 7;
    localparam int BCD_W        = 4;
    localparam int SHIFT_CYCLES = 7;

    localparam logic [BCD_W-1:0] BCD_ERR  = 4'hF;
    // Glyphs are active-high {g,f,e,d,c,b,a}; pin polarity is applied at the top.
    localparam logic [6:0]       SEG_DASH = 7'b1000000;

    function automatic logic [6:0] seg_encode(input logic [BCD_W-1:0] digit);
        logic [6:0] glyph;
        case (digit)
            4'd0:    glyph = 7'b0111111;
            4'd1:    glyph = 7'b0000110;
            4'd2:    glyph = 7'b1011011;
            4'd3:    glyph = 7'b1001111;
            4'd4:    glyph = 7'b1100110;
            4'd5:    glyph = 7'b1101101;
            4'd6:    glyph = 7'b1111101;
            4'd7:    glyph = 7'b0000111;
            4'd8:    glyph = 7'b1111111;
            4'd9:    glyph = 7'b1101111;
            default: glyph = SEG_DASH;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: a new value starts a 7-shift conversion
// and the result is published with a one-cycle bcd_valid pulse.
module bin2bcd_seq
    import mod100_disp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] value,
    output logic [BCD_W-1:0] bcd_tens,
    output logic [BCD_W-1:0] bcd_ones,
    output logic             bcd_valid,
    output logic             range_err
);

    localparam int SR_W = 3 * BCD_W + BIN_W;

    conv_state_e      state;
    conv_state_e      next_state;
    logic [SR_W-1:0]  sr;
    logic [SR_W-1:0]  sr_adj;
    logic [BIN_W-1:0] last_conv;
    logic [2:0]       bitcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (value != last_conv) next_state = SHIFT;
            SHIFT:   if (bitcnt == 3'(SHIFT_CYCLES - 1)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Add-3 correction on hundreds/tens/ones nibbles ahead of each shift.
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < 3; i++) begin
            if (sr[BIN_W + BCD_W*i +: BCD_W] >= 4'd5)
                sr_adj[BIN_W + BCD_W*i +: BCD_W] = sr[BIN_W + BCD_W*i +: BCD_W] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr        <= '0;
            last_conv <= '0;
            bitcnt    <= '0;
            bcd_tens  <= '0;
            bcd_ones  <= '0;
            bcd_valid <= 1'b0;
            range_err <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (value != last_conv) begin
                        sr        <= {{(3*BCD_W){1'b0}}, value};
                        last_conv <= value;
                        bitcnt    <= '0;
                    end
                end
                SHIFT: begin
                    sr     <= {sr_adj[SR_W-2:0], 1'b0};
                    bitcnt <= bitcnt + 3'd1;
                end
                DONE: begin
                    bcd_valid <= 1'b1;
                    // A non-zero hundreds nibble means the input exceeded 99.
                    if (sr[SR_W-1 -: BCD_W] != '0) begin
                        bcd_tens  <= BCD_ERR;
                        bcd_ones  <= BCD_ERR;
                        range_err <= 1'b1;
                    end else begin
                        bcd_tens  <= sr[BIN_W + BCD_W +: BCD_W];
                        bcd_ones  <= sr[BIN_W +: BCD_W];
                        range_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mod100_bcd_display.sv
// Display front-end for the mod-100 counter: input register, 99->0 wrap detect,
// BCD conversion and a two-digit multiplexed seven-segment scan.
module mod100_bcd_display
    import mod100_disp_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] tod,
    output logic [BCD_W-1:0] bcd_tens,
    output logic [BCD_W-1:0] bcd_ones,
    output logic             bcd_valid,
    output logic             range_err,
    output logic             wrap_pulse,
    output logic [6:0]       seg,
    output logic [1:0]       an
);

    localparam int PS_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [BIN_W-1:0] tod_q;
    logic [PS_W-1:0]  prescaler;
    logic             digit_sel;  // 0 = ones, 1 = tens
    logic [6:0]       seg_on;
    logic [1:0]       an_on;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tod_q      <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            tod_q      <= tod;
            wrap_pulse <= (tod_q == 7'd99) && (tod == 7'd0);
        end
    end

    bin2bcd_seq u_conv (
        .clk       (clk),
        .rst       (rst),
        .value     (tod_q),
        .bcd_tens  (bcd_tens),
        .bcd_ones  (bcd_ones),
        .bcd_valid (bcd_valid),
        .range_err (range_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler <= '0;
            digit_sel <= 1'b0;
        end else if (prescaler == PS_W'(REFRESH_DIV - 1)) begin
            prescaler <= '0;
            digit_sel <= ~digit_sel;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_comb begin
        seg_on = seg_encode(digit_sel ? bcd_tens : bcd_ones);
        an_on  = digit_sel ? 2'b10 : 2'b01;
    end

    // Pins are registered so the reset state is "all dark" in either polarity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= {7{SEG_ACTIVE_LOW}};
            an  <= {2{SEG_ACTIVE_LOW}};
        end else begin
            seg <= seg_on ^ {7{SEG_ACTIVE_LOW}};
            an  <= an_on ^ {2{SEG_ACTIVE_LOW}};
        end
    end

endmodule
